// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Constants shared by the 16x8 FIFO memory and its pointer/flag controller.
//   FIFO_ADDR_W  memory address width
//   FIFO_DEPTH   number of memory words (2**FIFO_ADDR_W)
//   FIFO_DATA_W  memory word width
//   ptr_t        pointer type: address bits plus one wrap bit
//   data_t       memory word type
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_W = 4;
    localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
    localparam int FIFO_DATA_W = 8;

    typedef logic [FIFO_ADDR_W:0]   ptr_t;
    typedef logic [FIFO_DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl_if
//   Request/status bundle between producer/consumer logic (master) and the
//   FIFO pointer controller (slave). Carries no data; the memory data path is
//   wired separately.
//   master drives : flush, wr_req, rd_req
//   slave drives  : mem_we, mem_w_addr, mem_re, mem_r_addr, rd_valid,
//                   full, empty, almost_full, almost_empty, count,
//                   overflow, underflow
// -----------------------------------------------------------------------------
interface fifo_ptr_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) ();

    logic              flush;
    logic              wr_req;
    logic              rd_req;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_w_addr;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_r_addr;
    logic              rd_valid;

    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_req, rd_req,
        input  mem_we, mem_w_addr, mem_re, mem_r_addr, rd_valid,
        input  full, empty, almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  flush, wr_req, rd_req,
        output mem_we, mem_w_addr, mem_re, mem_r_addr, rd_valid,
        output full, empty, almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   16x8 FIFO storage. Pure storage: no pointers, no flags, no reset on data.
//   Synchronous write; registered read (dout updates one edge after re).
//   clk     in   clock
//   we      in   write enable
//   w_addr  in   write address
//   din     in   write data
//   re      in   read enable
//   r_addr  in   read address
//   dout    out  registered read data, holds until the next read
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= din;
        end
        if (re) begin
            dout <= mem[r_addr];
        end
    end

endmodule

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
//   Wrap-bit pointer register. ADDR_W address bits plus one wrap bit; the
//   natural binary carry out of the address bits toggles the wrap bit, so
//   address 2**ADDR_W-1 wraps to 0 with the wrap bit flipped.
//   Priority: rst > load > inc.
//   clk       in   clock
//   rst       in   synchronous active-high reset, pointer -> 0
//   inc       in   advance pointer by one
//   load      in   replace pointer with load_val
//   load_val  in   value used by load
//   ptr       out  current pointer
// -----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            load,
    input  logic [ADDR_W:0] load_val,
    output logic [ADDR_W:0] ptr
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Pointer/flag controller for the 16x8 FIFO memory. Generates the memory
//   write/read enables and addresses from two wrap-bit pointers, derives
//   full/empty/almost flags and occupancy, aligns rd_valid with the memory's
//   registered dout and keeps sticky overflow/underflow error flags.
//   clk   in      clock, all state on rising edge
//   rst   in      synchronous active-high reset; dominates flush and requests
//   bus   slave   request/status bundle (see fifo_ptr_ctrl_if)
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W       = FIFO_ADDR_W,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_ptr_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(ALMOST_FULL);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(ALMOST_EMPTY);

    // Occupancy is the modular pointer difference; the wrap bit makes 0 and
    // DEPTH distinguishable.
    function automatic logic [ADDR_W:0] occupancy(input logic [ADDR_W:0] w,
                                                  input logic [ADDR_W:0] r);
        return w - r;
    endfunction

    function automatic logic ptrs_full(input logic [ADDR_W:0] w,
                                       input logic [ADDR_W:0] r);
        return (w[ADDR_W] != r[ADDR_W]) && (w[ADDR_W-1:0] == r[ADDR_W-1:0]);
    endfunction

    logic [ADDR_W:0] wptr;
    logic [ADDR_W:0] rptr;
    logic [ADDR_W:0] occ;
    logic            full_c;
    logic            empty_c;
    logic            hold;
    logic            wr_acc;
    logic            rd_acc;
    logic            wr_err;
    logic            rd_err;
    logic            rd_vld_p1;
    logic            ovf_q;
    logic            unf_q;

    always_comb begin
        occ     = occupancy(wptr, rptr);
        full_c  = ptrs_full(wptr, rptr);
        empty_c = (wptr == rptr);

        // Reset and flush both suppress every request for the cycle.
        hold    = rst | bus.flush;

        // No pass-through when full and no bypass when empty: acceptance
        // depends only on the current pointers, never on the other request.
        wr_acc  = bus.wr_req & ~full_c  & ~hold;
        rd_acc  = bus.rd_req & ~empty_c & ~hold;

        wr_err  = bus.wr_req & full_c  & ~hold;
        rd_err  = bus.rd_req & empty_c & ~hold;
    end

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (wr_acc),
        .load     (1'b0),
        .load_val ({(ADDR_W+1){1'b0}}),
        .ptr      (wptr)
    );

    // Flush discards the contents by catching the read pointer up to the
    // write pointer; the memory itself is left alone.
    fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk      (clk),
        .rst      (rst),
        .inc      (rd_acc),
        .load     (bus.flush),
        .load_val (wptr),
        .ptr      (rptr)
    );

    // ---- stage p1: read issued last cycle, memory dout now valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_err) begin
                ovf_q <= 1'b1;
            end
            if (rd_err) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.mem_we       = wr_acc;
    assign bus.mem_w_addr   = wptr[ADDR_W-1:0];
    assign bus.mem_re       = rd_acc;
    assign bus.mem_r_addr   = rptr[ADDR_W-1:0];
    assign bus.rd_valid     = rd_vld_p1;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.count        = occ;
    assign bus.almost_full  = (occ >= AF_LVL);
    assign bus.almost_empty = (occ <= AE_LVL);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule
